// File: rtl/flag_xfer_pkg.sv
// flag_xfer_pkg: shared types and helpers for the flag serial transfer engine.
//   xfer_state_e : engine state (IDLE / CAP / INJ)
//   ALU_SHL      : ALU function code for "A plus A" (left shift through carry)
//   slot_w/bit_w/cnt_w : width helpers for slot address, bit index, step count
package flag_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    INJ  = 2'd2
  } xfer_state_e;

  localparam logic [3:0] ALU_SHL = 4'b1100;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int bit_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flag_xfer_slots.sv
// flag_xfer_slots: NUM_SLOTS x DATA_W slot register file.
//   clk, rst_n          : clock, async active-low reset (slots -> INIT_VAL)
//   we/wslot/wbit/wdata : single-bit write port
//   xslot -> xdata      : read port for the slot under transfer
//   rd_slot -> rd_data  : combinational display read port
// Build option XFER_PARITY_EN adds one parity bit per slot (reset 0):
//   par_we/par_wdata write parity of wslot; xpar / rd_parity read it back.
module flag_xfer_slots
  import flag_xfer_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              NUM_SLOTS = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = 'hAA,
  localparam int             SW        = slot_w(NUM_SLOTS),
  localparam int             BW        = bit_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [SW-1:0]     wslot,
  input  logic [BW-1:0]     wbit,
  input  logic              wdata,
  input  logic [SW-1:0]     xslot,
  output logic [DATA_W-1:0] xdata,
  input  logic [SW-1:0]     rd_slot,
  output logic [DATA_W-1:0] rd_data
`ifdef XFER_PARITY_EN
  ,
  input  logic              par_we,
  input  logic              par_wdata,
  output logic              xpar,
  output logic              rd_parity
`endif
);

  logic [NUM_SLOTS-1:0][DATA_W-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= {NUM_SLOTS{INIT_VAL}};
    else if (we) mem[wslot][wbit] <= wdata;
  end

  assign xdata   = mem[xslot];
  assign rd_data = mem[rd_slot];

`ifdef XFER_PARITY_EN
  logic [NUM_SLOTS-1:0] par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par <= '0;
    else if (par_we) par[wslot] <= par_wdata;
  end

  assign xpar      = par[xslot];
  assign rd_parity = par[rd_slot];
`endif

endmodule

// File: rtl/flag_serial_xfer.sv
// flag_serial_xfer: moves whole words between internal slots and a datapath
// register one bit per step through the carry flag.
//   Capture (CAP): register is shifted left through the ALU (A plus A); each
//     carry-out arrives on C one step later and lands in the slot, MSB first.
//   Inject (INJ): slot bits, MSB first, are fed into the shift via CIN.
// Ports:
//   T3 clock, CLR async active-low reset
//   step_en qualifies a step; start_cap/start_inj request a transfer
//   slot_sel/reg_sel latched at start; C datapath carry flag
//   rd_slot -> rd_data combinational slot read
//   busy, done (completion-step pulse), count (step counter)
//   S, SEL, SELCTL, ABUS, DRW, LDC, LDZ, CIN, SHORT, STOP micro-op outputs
// Build option XFER_PARITY_EN: per-slot parity, rd_parity port, and STOP held
//   one extra step when an injected slot fails its parity check.
module flag_serial_xfer
  import flag_xfer_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                NUM_SLOTS   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL    = 8'hAA,
  parameter int                CIN_ACT_LOW = 1,
  localparam int               SW          = slot_w(NUM_SLOTS),
  localparam int               CW          = cnt_w(DATA_W)
) (
  input  logic              T3,
  input  logic              CLR,
  input  logic              step_en,
  input  logic              start_cap,
  input  logic              start_inj,
  input  logic [SW-1:0]     slot_sel,
  input  logic [1:0]        reg_sel,
  input  logic              C,
  input  logic [SW-1:0]     rd_slot,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     count,
  output logic [3:0]        S,
  output logic [3:0]        SEL,
  output logic              SELCTL,
  output logic              ABUS,
  output logic              DRW,
  output logic              LDC,
  output logic              LDZ,
  output logic              CIN,
  output logic              SHORT,
  output logic              STOP
`ifdef XFER_PARITY_EN
  ,
  output logic              rd_parity
`endif
);

  localparam int            BW   = bit_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  localparam logic          CINV = (CIN_ACT_LOW != 0);

  xfer_state_e       state, state_n;
  logic [CW-1:0]     count_n;
  logic [SW-1:0]     slot_q, slot_n;
  logic [1:0]        reg_q, reg_n;

  logic              s_we;
  logic [BW-1:0]     s_bit;
  logic [DATA_W-1:0] xdata;
  logic              shift, cin_l;

`ifdef XFER_PARITY_EN
  logic              hold_q, hold_n;
  logic              par_we, par_wdata, xpar;
`endif

  flag_xfer_slots #(
    .DATA_W   (DATA_W),
    .NUM_SLOTS(NUM_SLOTS),
    .INIT_VAL (INIT_VAL)
  ) u_slots (
    .clk      (T3),
    .rst_n    (CLR),
    .we       (s_we),
    .wslot    (slot_q),
    .wbit     (s_bit),
    .wdata    (C),
    .xslot    (slot_q),
    .xdata    (xdata),
    .rd_slot  (rd_slot),
    .rd_data  (rd_data)
`ifdef XFER_PARITY_EN
    ,
    .par_we   (par_we),
    .par_wdata(par_wdata),
    .xpar     (xpar),
    .rd_parity(rd_parity)
`endif
  );

  always_ff @(posedge T3 or negedge CLR) begin
    if (!CLR) begin
      state  <= IDLE;
      count  <= '0;
      slot_q <= '0;
      reg_q  <= '0;
`ifdef XFER_PARITY_EN
      hold_q <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      count  <= count_n;
      slot_q <= slot_n;
      reg_q  <= reg_n;
`ifdef XFER_PARITY_EN
      hold_q <= hold_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    slot_n  = slot_q;
    reg_n   = reg_q;
    done    = 1'b0;
    STOP    = 1'b0;
    s_we    = 1'b0;
    s_bit   = '0;
    shift   = 1'b0;
    cin_l   = 1'b0;
    LDC     = 1'b0;
    LDZ     = 1'b0;
`ifdef XFER_PARITY_EN
    hold_n    = hold_q;
    par_we    = 1'b0;
    par_wdata = ^{xdata[DATA_W-1:1], C};
`endif

    case (state)
      IDLE: if (step_en) begin
`ifdef XFER_PARITY_EN
        // extra STOP step after a parity-failed inject
        if (hold_q) begin
          STOP   = 1'b1;
          hold_n = 1'b0;
        end
`endif
        if (start_cap || start_inj) begin
          state_n = start_cap ? CAP : INJ;
          count_n = '0;
          slot_n  = slot_sel;
          reg_n   = reg_sel;
        end
      end
      CAP: if (step_en) begin
        // carry on C belongs to the shift issued one step earlier
        s_we  = (count != '0);
        s_bit = BW'(LAST - count);
        if (count == LAST) begin
          done    = 1'b1;
          STOP    = 1'b1;
          count_n = '0;
          state_n = IDLE;
`ifdef XFER_PARITY_EN
          par_we  = 1'b1;
`endif
        end else begin
          shift   = 1'b1;
          LDC     = 1'b1;
          LDZ     = 1'b1;
          count_n = count + CW'(1);
        end
      end
      INJ: if (step_en) begin
        if (count == LAST) begin
          done    = 1'b1;
          STOP    = 1'b1;
          count_n = '0;
          state_n = IDLE;
`ifdef XFER_PARITY_EN
          hold_n  = ((^xdata) != xpar);
`endif
        end else begin
          shift   = 1'b1;
          cin_l   = xdata[BW'(LAST - count - CW'(1))];
          count_n = count + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift micro-op fields are only driven on a step that actually shifts.
  always_comb begin
    S      = '0;
    SEL    = '0;
    SELCTL = 1'b0;
    ABUS   = 1'b0;
    DRW    = 1'b0;
    SHORT  = 1'b0;
    CIN    = 1'b0;
    if (shift) begin
      S      = ALU_SHL;
      SEL    = {reg_q, reg_q};
      SELCTL = 1'b1;
      ABUS   = 1'b1;
      DRW    = 1'b1;
      SHORT  = 1'b1;
      CIN    = cin_l ^ CINV;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_flag_serial_xfer.sv
module tb_flag_serial_xfer;

  logic       T3 = 1'b0, CLR = 1'b0;
  logic       step_en = 1'b0, start_cap = 1'b0, start_inj = 1'b0;
  logic [1:0] slot_sel = '0, reg_sel = '0, rd_slot = '0;
  logic       C;
  logic [7:0] rd_data;
  logic       busy, done;
  logic [3:0] count, S, SEL;
  logic       SELCTL, ABUS, DRW, LDC, LDZ, CIN, SHORT, STOP;
`ifdef XFER_PARITY_EN
  logic       rd_parity;
`endif

  int pass_n = 0, total_n = 0;

  flag_serial_xfer dut (
    .T3(T3), .CLR(CLR), .step_en(step_en), .start_cap(start_cap),
    .start_inj(start_inj), .slot_sel(slot_sel), .reg_sel(reg_sel), .C(C),
    .rd_slot(rd_slot), .rd_data(rd_data), .busy(busy), .done(done),
    .count(count), .S(S), .SEL(SEL), .SELCTL(SELCTL), .ABUS(ABUS),
    .DRW(DRW), .LDC(LDC), .LDZ(LDZ), .CIN(CIN), .SHORT(SHORT), .STOP(STOP)
`ifdef XFER_PARITY_EN
    , .rd_parity(rd_parity)
`endif
  );

  always #5 T3 = ~T3;

  // Datapath model: 4 registers, 74181-style A plus A with active-low carry-in,
  // carry flag loaded on LDC. SEL[3:2] = destination, SEL[1:0] = source.
  logic [7:0] R [4];
  logic       Cf = 1'b0;
  logic       ld_en = 1'b0;
  logic [1:0] ld_idx = '0;
  logic [7:0] ld_val = '0;
  assign C = Cf;

  always @(posedge T3) begin : dp
    logic [8:0] sum;
    if (ld_en) begin
      R[ld_idx] <= ld_val;
      Cf        <= 1'b0;
    end else if (DRW) begin
      sum = {R[SEL[1:0]], 1'b0} + {8'd0, ~CIN};
      R[SEL[3:2]] <= sum[7:0];
      if (LDC) Cf <= sum[8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge T3); #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [7:0] val);
    ld_idx = idx; ld_val = val; ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  typedef struct {
    logic       en, sc, si;
    logic       busy;
    logic [3:0] cnt;
    logic       dn, stp, drw, ldc, cin;
    logic [3:0] sel;
    logic [7:0] rd;
  } vec_t;

  vec_t v [13];
  logic [7:0] cap_rd [8];
  logic [7:0] inj_cin;
  int         n;
  logic       got;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // capture of R3=5C into slot 1: partial slot contents seen at each step
    cap_rd[0] = 8'hAA; cap_rd[1] = 8'hAA; cap_rd[2] = 8'h2A; cap_rd[3] = 8'h6A;
    cap_rd[4] = 8'h4A; cap_rd[5] = 8'h5A; cap_rd[6] = 8'h5A; cap_rd[7] = 8'h5E;
    // start row with both starts high: capture must win
    v[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'hAA};
    for (int k = 0; k < 8; k++)
      // start_inj pulsed at k=2 while busy: ignored
      v[k+1] = '{1'b1, 1'b0, (k == 2), 1'b1, 4'(k), 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, cap_rd[k]};
    v[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h5C};
    v[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h5C};
    // start without step_en must not begin a transfer
    v[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h5C};
    v[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h5C};
    inj_cin = 8'b1010_0011;

    // ---- reset state ----
    #12;
    for (int s = 0; s < 4; s++) begin
      rd_slot = 2'(s); #1;
      chk($sformatf("reset_slot%0d", s), rd_data, 8'hAA);
    end
    chk("reset_outputs",
        {busy, done, count, S, SEL, SELCTL, ABUS, DRW, LDC, LDZ, CIN, SHORT, STOP}, '0);
    CLR = 1'b1;
    tick();

    // ---- capture R3 -> slot 1, table driven ----
    load(2'd3, 8'h5C);
    rd_slot = 2'd1; slot_sel = 2'd1; reg_sel = 2'd3;
    for (int i = 0; i < 13; i++) begin
      step_en = v[i].en; start_cap = v[i].sc; start_inj = v[i].si;
      #3;
      chk($sformatf("cap_vec%0d", i),
          {busy, count, done, STOP, DRW, LDC, CIN, SEL},
          {v[i].busy, v[i].cnt, v[i].dn, v[i].stp, v[i].drw, v[i].ldc, v[i].cin, v[i].sel});
      chk($sformatf("cap_rd%0d", i), rd_data, v[i].rd);
      tick();
    end
    start_cap = 1'b0; start_inj = 1'b0;
    chk("cap_reg_cleared", R[3], 8'h00);

    // ---- inject slot 1 -> R2 ----
    load(2'd2, 8'h33);
    slot_sel = 2'd1; reg_sel = 2'd2;
    step_en = 1'b1; start_inj = 1'b1;
    tick();
    start_inj = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #3;
      chk($sformatf("inj_cin%0d", k), CIN, inj_cin[7-k]);
      chk($sformatf("inj_ctl%0d", k), {DRW, LDC, LDZ, SEL}, {1'b1, 1'b0, 1'b0, 4'b1010});
      tick();
    end
    #3;
    chk("inj_done", {done, STOP, DRW}, 3'b110);
    tick();
    step_en = 1'b0; #3;
    chk("inj_reg", R[2], 8'h5C);
    chk("inj_slot_kept", rd_data, 8'h5C);
    chk("inj_idle", busy, 1'b0);
    tick();

    // ---- capture with step_en gaps: R0=C3 -> slot 2 ----
    load(2'd0, 8'hC3);
    slot_sel = 2'd2; reg_sel = 2'd0; rd_slot = 2'd2;
    step_en = 1'b1; start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
    n = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step_en = (i % 2 == 0); #3;
      if (!step_en) chk($sformatf("gap_hold%0d", i), {DRW, LDC, count}, {2'b00, 4'(n)});
      else if (done) begin
        got = 1'b1;
        chk("gap_done_step", n, 8);
      end
      tick();
      if (step_en) n++;
    end
    if (!got) begin
      total_n++;
      $display("FAIL gap_timeout: done not seen within 40 cycles");
    end
    step_en = 1'b0; #3;
    chk("gap_slot", rd_data, 8'hC3);
    chk("gap_reg_cleared", R[0], 8'h00);
    tick();

    // ---- abort by CLR at count 4: R1=0F -> slot 3 ----
    load(2'd1, 8'h0F);
    slot_sel = 2'd3; reg_sel = 2'd1; rd_slot = 2'd3;
    step_en = 1'b1; start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    #3;
    chk("abort_pre_count", count, 4'd4);
    chk("abort_pre_partial", rd_data, 8'h0A);
    CLR = 1'b0; #1;
    chk("abort_state", {busy, count}, 5'd0);
    chk("abort_slot3", rd_data, 8'hAA);
    rd_slot = 2'd1; #1;
    chk("abort_slot1", rd_data, 8'hAA);
    step_en = 1'b0;
    tick();
    CLR = 1'b1;
    tick();

`ifdef XFER_PARITY_EN
    // ---- parity: capture 07 into slot 0, corrupt to 06, inject ----
    load(2'd0, 8'h07);
    slot_sel = 2'd0; reg_sel = 2'd0; rd_slot = 2'd0;
    step_en = 1'b1; start_cap = 1'b1;
    tick();
    start_cap = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    step_en = 1'b0; #3;
    chk("par_cap_data", rd_data, 8'h07);
    chk("par_cap_bit", rd_parity, 1'b1);
    force dut.u_slots.mem[0] = 8'h06;
    reg_sel = 2'd1;
    step_en = 1'b1; start_inj = 1'b1;
    tick();
    start_inj = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    #3;
    chk("par_stop_done", {done, STOP}, 2'b11);
    tick();
    #3;
    chk("par_stop_extra", {busy, done, STOP}, 3'b001);
    tick();
    #3;
    chk("par_stop_clear", STOP, 1'b0);
    release dut.u_slots.mem[0];
    step_en = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
